// File: rtl/hex_cmd_sequencer_if.sv
// Bus bundle between the command sequencer, the UART receiver, the ASCII-to-hex
// converter and the configuration register bank.
interface hex_cmd_sequencer_if #(
    parameter int ADDR_NIB = 2,
    parameter int DATA_NIB = 4
);
    logic [7:0]            rx_data;
    logic                  rx_vld;
    logic [7:0]            cvt_din;
    logic                  cvt_din_vld;
    logic [3:0]            cvt_dout;
    logic                  cvt_dout_vld;
    logic [4*ADDR_NIB-1:0] cfg_addr;
    logic [4*DATA_NIB-1:0] cfg_data;
    logic                  cfg_wr;
    logic                  err;
    logic [1:0]            err_code;
    logic                  busy;

    modport master (
        input  rx_data, rx_vld, cvt_dout, cvt_dout_vld,
        output cvt_din, cvt_din_vld, cfg_addr, cfg_data, cfg_wr, err, err_code, busy
    );

    modport slave (
        output rx_data, rx_vld, cvt_dout, cvt_dout_vld,
        input  cvt_din, cvt_din_vld, cfg_addr, cfg_data, cfg_wr, err, err_code, busy
    );
endinterface

// File: rtl/hex_cmd_sequencer.sv
// Frames UART bytes 'W' <addr hex> <data hex> CR into configuration writes,
// driving the external ASCII-to-hex converter one character at a time.
module hex_cmd_sequencer #(
    parameter int         ADDR_NIB    = 2,
    parameter int         DATA_NIB    = 4,
    parameter logic [7:0] START_CHAR  = 8'h57,
    parameter logic [7:0] END_CHAR    = 8'h0D,
    parameter int         TIMEOUT_CYC = 500000
) (
    input logic                  clk,
    input logic                  rst_n,
    hex_cmd_sequencer_if.master  bus
);
    localparam int AW = 4 * ADDR_NIB;
    localparam int DW = 4 * DATA_NIB;
    localparam int CW = $clog2(ADDR_NIB + DATA_NIB + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_END  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_pend,     w_pend_nxt;
    logic [CW-1:0]   r_cnt,      w_cnt_nxt;
    logic [TW-1:0]   r_tmo,      w_tmo_nxt;
    logic [AW-1:0]   r_addr_sh,  w_addr_sh_nxt;
    logic [DW-1:0]   r_data_sh,  w_data_sh_nxt;
    logic [AW-1:0]   r_cfg_addr, w_cfg_addr_nxt;
    logic [DW-1:0]   r_cfg_data, w_cfg_data_nxt;
    logic            r_cfg_wr,   w_cfg_wr_nxt;
    logic            r_err,      w_err_nxt;
    logic [1:0]      r_err_code, w_err_code_nxt;
    logic            r_busy;
    logic [7:0]      w_cvt_din;
    logic            w_cvt_din_vld;

    // A byte arriving while a conversion is still pending is dropped.
    logic          w_rx, w_is_start, w_is_end, w_in_frame, w_start, w_fwd;
    logic          w_cvt_ok, w_cvt_bad, w_end_ok, w_end_bad, w_tmo;
    logic [CW-1:0] w_cnt_inc, w_cnt_lim;

    assign w_rx       = bus.rx_vld && !r_pend;
    assign w_is_start = (bus.rx_data == START_CHAR);
    assign w_is_end   = (bus.rx_data == END_CHAR);
    assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_start    = w_rx && w_is_start;
    assign w_fwd      = w_in_frame && w_rx && !w_is_start;
    assign w_cvt_ok   = r_pend && bus.cvt_dout_vld;
    assign w_cvt_bad  = r_pend && !bus.cvt_dout_vld;
    assign w_end_ok   = (r_state == S_END) && w_rx && w_is_end;
    assign w_end_bad  = (r_state == S_END) && w_rx && !w_is_start && !w_is_end;
    // A byte arriving on the timeout cycle takes precedence over the abort.
    assign w_tmo      = (r_state != S_IDLE) && !bus.rx_vld && (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_cnt_lim  = (r_state == S_ADDR) ? CW'(ADDR_NIB) : CW'(DATA_NIB);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_ADDR;
                else         w_state_nxt = S_IDLE;
            end
            S_ADDR, S_DATA: begin
                if (w_start)                              w_state_nxt = S_ADDR;
                else if (w_cvt_bad || w_tmo)              w_state_nxt = S_IDLE;
                else if (w_cvt_ok && w_cnt_inc == w_cnt_lim)
                    w_state_nxt = (r_state == S_ADDR) ? S_DATA : S_END;
                else                                      w_state_nxt = r_state;
            end
            S_END: begin
                if (w_end_ok || w_end_bad || w_tmo) w_state_nxt = S_IDLE;
                else if (w_start)                   w_state_nxt = S_ADDR;
                else                                w_state_nxt = S_END;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next-value logic.
    always_comb begin
        w_cvt_din      = w_fwd ? bus.rx_data : 8'h00;
        w_cvt_din_vld  = w_fwd;
        w_pend_nxt     = w_fwd;
        w_cnt_nxt      = r_cnt;
        w_addr_sh_nxt  = r_addr_sh;
        w_data_sh_nxt  = r_data_sh;
        if (w_start) begin
            w_cnt_nxt     = {CW{1'b0}};
            w_addr_sh_nxt = {AW{1'b0}};
            w_data_sh_nxt = {DW{1'b0}};
        end else if (w_cvt_ok) begin
            if (r_state == S_ADDR) begin
                w_addr_sh_nxt = AW'({r_addr_sh, bus.cvt_dout});
                w_cnt_nxt     = (w_cnt_inc == w_cnt_lim) ? {CW{1'b0}} : w_cnt_inc;
            end else begin
                w_data_sh_nxt = DW'({r_data_sh, bus.cvt_dout});
                w_cnt_nxt     = w_cnt_inc;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end

        if (r_state == S_IDLE || bus.rx_vld) w_tmo_nxt = {TW{1'b0}};
        else                                 w_tmo_nxt = r_tmo + TW'(1);

        w_cfg_wr_nxt = w_end_ok;
        if (w_end_ok) begin
            w_cfg_addr_nxt = r_addr_sh;
            w_cfg_data_nxt = r_data_sh;
        end else begin
            w_cfg_addr_nxt = r_cfg_addr;
            w_cfg_data_nxt = r_cfg_data;
        end

        w_err_nxt = w_cvt_bad || w_end_bad || w_tmo;
        if (w_cvt_bad)      w_err_code_nxt = 2'd1;
        else if (w_end_bad) w_err_code_nxt = 2'd2;
        else if (w_tmo)     w_err_code_nxt = 2'd3;
        else                w_err_code_nxt = r_err_code;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_cnt      <= {CW{1'b0}};
            r_tmo      <= {TW{1'b0}};
            r_addr_sh  <= {AW{1'b0}};
            r_data_sh  <= {DW{1'b0}};
            r_cfg_addr <= {AW{1'b0}};
            r_cfg_data <= {DW{1'b0}};
            r_cfg_wr   <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_busy     <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tmo      <= w_tmo_nxt;
            r_addr_sh  <= w_addr_sh_nxt;
            r_data_sh  <= w_data_sh_nxt;
            r_cfg_addr <= w_cfg_addr_nxt;
            r_cfg_data <= w_cfg_data_nxt;
            r_cfg_wr   <= w_cfg_wr_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.cvt_din     = w_cvt_din;
    assign bus.cvt_din_vld = w_cvt_din_vld;
    assign bus.cfg_addr    = r_cfg_addr;
    assign bus.cfg_data    = r_cfg_data;
    assign bus.cfg_wr      = r_cfg_wr;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_hex_cmd_sequencer.sv
// Scoreboard bench for hex_cmd_sequencer: directed frames push expected
// write/error events; a negedge monitor pops and compares them.
module tb_hex_cmd_sequencer;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    hex_cmd_sequencer_if #(.ADDR_NIB(2), .DATA_NIB(4)) bus ();

    hex_cmd_sequencer #(
        .ADDR_NIB(2), .DATA_NIB(4), .START_CHAR(8'h57), .END_CHAR(8'h0D), .TIMEOUT_CYC(100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c <= 8'h39)      return 4'(c - 8'h30);
        else if (c <= 8'h46) return 4'(c - 8'h37);
        else                 return 4'(c - 8'h57);
    endfunction

    // Behavioural ASCII-to-hex converter: answers one cycle later, only for hex digits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cvt_dout_vld <= 1'b0;
            bus.cvt_dout     <= 4'h0;
        end else begin
            bus.cvt_dout_vld <= bus.cvt_din_vld && is_hex(bus.cvt_din);
            bus.cvt_dout     <= hex_val(bus.cvt_din);
        end
    end

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d, input int lat);
        exp_t e;
        e.is_wr = 1'b1; e.addr = a; e.data = d; e.code = 2'd0; e.cyc = cyc + lat;
        q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code, input int lat);
        exp_t e;
        e.is_wr = 1'b0; e.addr = 8'h00; e.data = 16'h0000; e.code = code; e.cyc = cyc + lat;
        q.push_back(e);
    endtask

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        @(negedge clk);
        bus.rx_vld  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Monitor: every write or error strobe must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cvt_din_vld) check("cvt_vld_while_busy", {31'd0, bus.busy}, 32'd1);
            if (bus.cfg_wr || bus.err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: cfg_wr=%0b err=%0b code=%0d at cycle %0d, expected none",
                             bus.cfg_wr, bus.err, bus.err_code, cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("wr_err_exclusive", {31'd0, bus.cfg_wr & bus.err}, 32'd0);
                    check("event_kind", {31'd0, bus.cfg_wr}, {31'd0, mon_e.is_wr});
                    check("event_cycle", cyc, mon_e.cyc);
                    check("busy_at_event", {31'd0, bus.busy}, 32'd0);
                    if (mon_e.is_wr) begin
                        check("cfg_addr", {24'd0, bus.cfg_addr}, {24'd0, mon_e.addr});
                        check("cfg_data", {16'd0, bus.cfg_data}, {16'd0, mon_e.data});
                    end else begin
                        check("err_code", {30'd0, bus.err_code}, {30'd0, mon_e.code});
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cfg_wr"}, {31'd0, bus.cfg_wr}, 32'd0);
        check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
        check({tag, "_err_code"}, {30'd0, bus.err_code}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_cvt_din_vld"}, {31'd0, bus.cvt_din_vld}, 32'd0);
        check({tag, "_cfg_addr"}, {24'd0, bus.cfg_addr}, 32'd0);
        check({tag, "_cfg_data"}, {16'd0, bus.cfg_data}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_vld  = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame with mixed-case hex.
        send_str("W1AbC03");
        push_wr(8'h1A, 16'hBC03, 1);
        send_byte(8'h0D);
        repeat (3) @(negedge clk);
        check("t1_busy_after", {31'd0, bus.busy}, 32'd0);

        // Non-hex character aborts; next frame still works.
        send_str("W1");
        push_err(2'd1, 2);
        send_str("G");
        repeat (2) @(negedge clk);
        check("t2_busy_after_err", {31'd0, bus.busy}, 32'd0);
        send_str("W001234");
        push_wr(8'h00, 16'h1234, 1);
        send_byte(8'h0D);
        repeat (2) @(negedge clk);

        // Bad terminator: registers hold their previous values.
        send_str("W22FFFF");
        push_err(2'd2, 1);
        send_str("X");
        repeat (2) @(negedge clk);
        check("t3_addr_hold", {24'd0, bus.cfg_addr}, 32'h00);
        check("t3_data_hold", {16'd0, bus.cfg_data}, 32'h1234);

        // Timeout 100 cycles after the last byte.
        send_str("W");
        push_err(2'd3, 101);
        send_str("5");
        check("t4_busy_before_tmo", {31'd0, bus.busy}, 32'd1);
        repeat (105) @(negedge clk);
        check("t4_busy_after_tmo", {31'd0, bus.busy}, 32'd0);
        check("t4_err_code_held", {30'd0, bus.err_code}, 32'd3);

        // Idle garbage ignored, mid-frame resync.
        send_str("3Z");
        check("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
        send_str("W7W230001");
        push_wr(8'h23, 16'h0001, 1);
        send_byte(8'h0D);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-frame, then a clean frame.
        send_str("W1");
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_str("W55AA55");
        push_wr(8'h55, 16'hAA55, 1);
        send_byte(8'h0D);
        repeat (3) @(negedge clk);
        check("t6_addr_hold", {24'd0, bus.cfg_addr}, 32'h55);
        check("t6_data_hold", {16'd0, bus.cfg_data}, 32'hAA55);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_cmd_sequencer.md
Name: hex_cmd_sequencer

Overview:
- Frames the UART receive byte stream into configuration write commands for the temperature monitor.
- Sequences the ASCII-to-hex nibble converter: forwards payload characters to it, collects the returned nibbles, and assembles address and data words.
- On a complete frame, issues a single-cycle write strobe to the configuration register bank.
- Frame format: START_CHAR, ADDR_NIB hex chars, DATA_NIB hex chars, END_CHAR. Hex chars are MSB nibble first.

Parameters:
- ADDR_NIB, 2: number of address hex characters; cfg_addr width = 4*ADDR_NIB.
- DATA_NIB, 4: number of data hex characters; cfg_data width = 4*DATA_NIB.
- START_CHAR, 8'h57 ('W'): frame start byte.
- END_CHAR, 8'h0D (CR): frame terminator byte.
- TIMEOUT_CYC, 500000: idle cycles allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received UART byte
- rx_vld  in  1  rx_data valid, 1-cycle pulse
- cvt_din  out  8  byte to converter
- cvt_din_vld  out  1  converter input valid
- cvt_dout  in  4  converter nibble result
- cvt_dout_vld  in  1  converter result valid; exactly 1 cycle after cvt_din_vld when the byte is 0-9, A-F or a-f, otherwise stays 0
- cfg_addr  out  4*ADDR_NIB  assembled address
- cfg_data  out  4*DATA_NIB  assembled data
- cfg_wr  out  1  write strobe, 1 cycle
- err  out  1  frame error pulse, 1 cycle
- err_code  out  2  1 = non-hex char, 2 = bad terminator, 3 = timeout; held until next err
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, nibble counter 0, timeout counter 0.
- rx_vld pulses are guaranteed at least 2 cycles apart. The block relies on this; a byte arriving while a conversion is pending is dropped.
- States: IDLE, ADDR, DATA, END.
- IDLE:
  - rx_vld with rx_data==START_CHAR: clear shift registers and nibble counter, go to ADDR.
  - All other bytes are ignored.
- ADDR/DATA, rx_vld at cycle T:
  - If rx_data==START_CHAR: resync. Clear shift registers and counter, go to ADDR, no err. The byte is not forwarded.
  - Otherwise drive cvt_din=rx_data and cvt_din_vld=1 combinationally in cycle T, and set pend=1.
- Cycle T+1 with pend=1:
  - If cvt_dout_vld=1: shift cvt_dout into the LSB of the current shift register and increment the counter.
  - Counter reaching ADDR_NIB in ADDR: go to DATA, counter reset to 0.
  - Counter reaching DATA_NIB in DATA: go to END.
  - If cvt_dout_vld=0: err=1, err_code=1, go to IDLE.
  - pend clears in T+1.
- END, rx_vld:
  - rx_data==END_CHAR: cfg_addr/cfg_data load the assembled words and cfg_wr=1 in the next cycle; go to IDLE.
  - rx_data==START_CHAR: resync to ADDR.
  - Anything else: err=1, err_code=2, go to IDLE.
- cfg_addr/cfg_data update only on a successful frame and hold otherwise. cvt_din_vld is never asserted in IDLE or END.
- Timeout:
  - The counter clears on every rx_vld and whenever in IDLE, and increments each cycle in ADDR/DATA/END.
  - On reaching TIMEOUT_CYC-1: err=1, err_code=3, go to IDLE.
  - If timeout and rx_vld coincide, rx_vld wins (the counter clears and the byte is processed).
- Simultaneous events: cfg_wr and err never assert together. The assembled frame is discarded on any error.
- Asynchronous reset mid-frame: immediately returns to IDLE, with no cfg_wr and no err.

Test Plan:
- 'W','1','A','b','C','0','3',0x0D with a behavioural converter model -> exactly one cfg_wr pulse, 1 cycle after CR; cfg_addr=8'h1A, cfg_data=16'hBC03; busy low afterwards.
- 'W','1','G' -> cvt_dout_vld stays 0, so err pulse with err_code=1, no cfg_wr, state IDLE; a following valid frame 'W','0','0','1','2','3','4',CR still gives cfg_addr=8'h00, cfg_data=16'h1234.
- 'W','2','2','F','F','F','F','X' -> err_code=2, no cfg_wr; cfg_addr/cfg_data keep their prior values.
- With TIMEOUT_CYC=100: 'W','5' then silence -> err pulse with err_code=3 exactly 100 cycles after the '5' rx_vld; busy drops in the same cycle.
- Garbage '3','Z' while idle, then 'W','7','W','2','3','0','0','0','1',CR -> garbage ignored; resync gives cfg_addr=8'h23, cfg_data=16'h0001, and no err.
- Assert rst_n low after 'W','1' -> all outputs 0; after release, a full valid frame is accepted normally.
